// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, with a
// valid/ready handshake on the operand side and on the result side.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_reg;
  logic [IDX_W-1:0] idx;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;

  assign last_bit = (idx == LAST_IDX);
  assign a_bit    = a_reg[idx];
  assign b_bit    = b_reg[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The carry register doubles as the carry-out once the MSB slice has run.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      c_reg   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            sum_reg <= '0;
            c_reg   <= cin;
            idx     <= '0;
          end
        end
        ADD: begin
          sum_reg[idx] <= a_bit ^ b_bit ^ c_reg;
          c_reg        <= (a_bit & b_bit) | (a_bit & c_reg) | (b_bit & c_reg);
          idx          <= last_bit ? '0 : idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign sum   = sum_reg;
  assign carry = c_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder: the driver queues the
// arithmetic sum of each accepted set, a monitor checks results and handshakes.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];
  int             force_delay = -1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: compares each result on its first DONE cycle, then holds it under
  // backpressure for a random (or forced) number of cycles before consuming.
  int             wait_left  = 0;
  bit             prev_valid = 0;
  bit             hs_pending = 0;
  logic [WIDTH-1:0] held_sum;
  logic             held_carry;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      hs_pending = 0;
      out_ready  = 1'b0;
    end else if (hs_pending) begin
      check_output("valid_drop", longint'(out_valid), 0);
      check_output("ready_rise", longint'(in_ready), 1);
      hs_pending = 0;
      prev_valid = 0;
      out_ready  = 1'($urandom_range(0, 1));
    end else if (out_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_valid", longint'(out_valid), 0);
        end else begin
          check_output("latency", longint'(cycle - acc_q[0]), WIDTH);
          check_output("result", longint'({carry, sum}), longint'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        held_sum   = sum;
        held_carry = carry;
        wait_left  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        prev_valid = 1;
      end else begin
        check_output("sum_stable", longint'(sum), longint'(held_sum));
        check_output("carry_stable", longint'(carry), longint'(held_carry));
      end
      check_output("ready_low_in_done", longint'(in_ready), 0);
      if (wait_left == 0) begin
        out_ready  = 1'b1;
        hs_pending = 1;
      end else begin
        out_ready = 1'b0;
        wait_left--;
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    int n = 0;
    logic [WIDTH:0] e;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("accept_timeout", longint'(in_ready), 1);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    e        = ta;
    e        = e + tb + tc;
    exp_q.push_back(e);
    acc_q.push_back(cycle + 1);
    @(posedge clk);
  endtask

  // Operand inputs and in_valid are scrambled while the add is in progress.
  task automatic apply_stimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    accept(ta, tb, tc);
    repeat (WIDTH - 1) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready || hs_pending) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_in_ready", longint'(in_ready), 1);
    check_output("reset_out_valid", longint'(out_valid), 0);
    check_output("reset_sum", longint'(sum), 0);
    check_output("reset_carry", longint'(carry), 0);
    rst = 1'b0;

    $display("[TB] directed operand sets");
    apply_stimulus(8'hFF, 8'h01, 1'b0);
    wait_idle();
    apply_stimulus(8'hA5, 8'h5A, 1'b1);
    wait_idle();
    apply_stimulus(8'h00, 8'h00, 1'b1);
    wait_idle();
    apply_stimulus(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    $display("[TB] backpressure for 5 cycles");
    force_delay = 5;
    apply_stimulus(8'h3C, 8'hC4, 1'b0);
    wait_idle();
    force_delay = -1;

    $display("[TB] reset during ADD");
    accept(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_output("abort_in_ready", longint'(in_ready), 1);
    check_output("abort_out_valid", longint'(out_valid), 0);
    check_output("abort_sum", longint'(sum), 0);
    check_output("abort_carry", longint'(carry), 0);
    rst = 1'b0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      check_output("abort_no_valid", longint'(out_valid), 0);
    end
    apply_stimulus(8'h80, 8'h7F, 1'b1);
    wait_idle();

    $display("[TB] random operand sets");
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
